bip_debug_tx: RTL and testbench
===============================

# bip_debug_tx

Halt-triggered debug reporter for the BIP accumulator processor. Sits directly downstream of the instruction decoder and consumes its `wr_uart` strobe, which the decoder raises while the HLT opcode is present. On halt it snapshots the program counter, the accumulator and an internal run-cycle counter. It streams them as a fixed 7-byte frame to the UART transmitter through a start/done byte handshake.

## Interface
- `PC_WIDTH`, 11, program counter width; legal range 1..16, zero-extended to 16 bits in the frame
- `HEADER`, 8'hA5, first byte of every frame
- `clk`  input  1  system clock, all logic on rising edge
- `reset`  input  1  synchronous, active-high reset
- `wr_uart`  input  1  halt indication from the instruction decoder; held high for as long as HLT is decoded
- `pc`  input  PC_WIDTH  current program counter
- `acc`  input  16  current accumulator value
- `tx_done_tick`  input  1  one-cycle pulse from the UART TX when the current byte has finished
- `tx_start`  output  1  one-cycle request to the UART TX to send `tx_data`
- `tx_data`  output  8  byte to transmit; stable from the `tx_start` cycle until `tx_done_tick`
- `busy`  output  1  high while a frame is in progress
- `done`  output  1  high after a full frame has been sent, until halt is released

## Operation
- Cycle counter `cyc` is 16 bits.
  - Increments once per clock while state is IDLE and `wr_uart`=0.
  - Saturates at 16'hFFFF and does not wrap.
  - Cleared on reset and on the DONE→IDLE transition.
- Halt trigger is the rising edge of `wr_uart`: `wr_uart`=1 while the registered previous value is 0.
  - The trigger is accepted only in IDLE; it is ignored in every other state.
- On trigger, the block latches three snapshots, all using values present in the trigger cycle:
  - `snap_cyc` = `cyc`
  - `snap_pc` = {zeros, `pc`}
  - `snap_acc` = `acc`
- Frame order is index 0..6:
  - 0: `HEADER`
  - 1: `snap_cyc[15:8]`, 2: `snap_cyc[7:0]`
  - 3: `snap_pc[15:8]`, 4: `snap_pc[7:0]`
  - 5: `snap_acc[15:8]`, 6: `snap_acc[7:0]`
- The frame uses a 3-bit byte index; it never exceeds 6.
- FSM states: IDLE, SEND, WAIT, DONE.
  - IDLE → SEND on trigger; index set to 0.
  - SEND: `tx_start`=1 for exactly this one cycle, `tx_data` = byte[index]; go to WAIT unconditionally.
  - WAIT, `tx_done_tick`=1 and index<6: index increments, go to SEND.
  - WAIT, `tx_done_tick`=1 and index=6: go to DONE.
  - WAIT, `tx_done_tick`=0: stay in WAIT; there is no timeout.
  - DONE → IDLE when `wr_uart`=0.
- `busy`=1 in SEND and WAIT. `done`=1 in DONE only.
- `tx_done_tick` outside WAIT is ignored.
- Changes on `pc`/`acc` after the trigger do not alter the frame.

## Timing
- All outputs are registered.
- Reset values:
  - `tx_start`=0, `tx_data`=8'h00, `busy`=0, `done`=0
  - state=IDLE, `cyc`=0, index=0, edge register=0
- Trigger seen in cycle T: `tx_start` and the header byte appear in cycle T+1, and `busy` rises in T+1.
- `tx_done_tick` in cycle D (index<6): the next `tx_start` occurs in D+1.
- The final `tx_done_tick` in cycle D: `busy` falls and `done` rises in D+1.
- With a TX that answers in L cycles after `tx_start`, the frame occupies 7·(L+1) cycles.
- `wr_uart` low in DONE at cycle R: `done`=0 in R+1, and counting resumes from 0 in the cycle after that.
- Reset asserted in any state: the next cycle is IDLE with all reset values.
  - A partially sent frame is abandoned and is not resumed.
- `wr_uart` held high continuously after DONE→IDLE does not retrigger; a new 0→1 edge is required.
- `wr_uart` dropping while in SEND or WAIT does not abort the frame.

## Test plan
- Reset release, `wr_uart`=0 for 20 cycles, then rise with `pc`=11'h005 and `acc`=16'h1234, TX answering after 3 cycles. Expected bytes: A5, 00, 14, 00, 05, 12, 34.
  - `tx_start` occurs 7 times, each 4 cycles apart.
  - `done`=1 after the last byte.
- Change `pc`/`acc` every cycle during the frame. Expected: the bytes equal the trigger-cycle snapshot.
- Run 70000 cycles before halt. Expected: bytes 1-2 = FF, FF (saturation).
- `PC_WIDTH`=11 with `pc`=11'h7FF. Expected: bytes 3-4 = 07, FF.
- Assert `reset` while in WAIT after byte 3. Expected:
  - `busy`=0 and `tx_start`=0 the next cycle.
  - Keep `wr_uart` at 0 for one cycle then 1: a fresh frame starts with A5, and the counter restarted after reset.
- Hold `wr_uart` high through DONE. Expected: `done` stays 1 and there is no retrigger.
  - Drop `wr_uart` for 1 cycle then raise it again. Expected: `done` clears, and the second frame reports a cycle count of 1.

Source files
------------

// File: rtl/bip_debug_tx.sv
// bip_debug_tx
// -----------------------------------------------------------------------------
// Halt-triggered debug reporter for the BIP accumulator processor.
//
// The decoder holds wr_uart high while HLT is decoded. On the rising edge of
// wr_uart (accepted only while idle), the block snapshots the free-running
// run-cycle counter, the program counter and the accumulator. It then streams
// a 7-byte frame to a UART transmitter, one byte per start/done handshake:
//
//   HEADER, cyc[15:8], cyc[7:0], pc[15:8], pc[7:0], acc[15:8], acc[7:0]
//
// The run-cycle counter advances once per idle clock while wr_uart is low. It
// saturates at 16'hFFFF and restarts from zero when halt is released.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-high reset
//   wr_uart       in   halt indication from the decoder (level)
//   pc            in   current program counter, PC_WIDTH bits
//   acc           in   current accumulator, 16 bits
//   tx_done_tick  in   one-cycle pulse when the UART TX finishes a byte
//   tx_start      out  one-cycle request to the UART TX to send tx_data
//   tx_data       out  byte to transmit, held until the matching done tick
//   busy          out  high while a frame is in progress
//   done          out  high after a full frame, until halt is released
//
// All outputs are registered. They are computed from the next state and then
// loaded into flops, so each output lines up with the state it describes.
// -----------------------------------------------------------------------------
module bip_debug_tx #(
  parameter int          PC_WIDTH = 11,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_uart,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [15:0]         acc,
  input  logic                tx_done_tick,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'd6;

  state_t      state;
  state_t      state_next;
  logic [2:0]  idx;
  logic [2:0]  idx_next;
  logic        wr_uart_p1;
  logic        trigger;
  logic        load_snap;
  logic [15:0] cyc;
  logic [15:0] cyc_next;

  logic [15:0] snap_cyc;
  logic [15:0] snap_pc;
  logic [15:0] snap_acc;

  logic        tx_start_next;
  logic [7:0]  tx_data_next;
  logic        busy_next;
  logic        done_next;

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end
    return v + 16'd1;
  endfunction

  // Frame layout, indexed 0..6.
  function automatic logic [7:0] frame_byte(
    input logic [2:0]  i,
    input logic [15:0] c,
    input logic [15:0] p,
    input logic [15:0] a
  );
    case (i)
      3'd0:    return HEADER;
      3'd1:    return c[15:8];
      3'd2:    return c[7:0];
      3'd3:    return p[15:8];
      3'd4:    return p[7:0];
      3'd5:    return a[15:8];
      3'd6:    return a[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // Rising edge of the halt level; only acted upon in IDLE.
  assign trigger = wr_uart && !wr_uart_p1;

  // Next-state and next-output logic.
  always_comb begin
    state_next   = state;
    idx_next     = idx;
    load_snap    = 1'b0;
    tx_data_next = tx_data;
    cyc_next     = cyc;

    case (state)
      IDLE: begin
        if (trigger) begin
          state_next   = SEND;
          idx_next     = 3'd0;
          load_snap    = 1'b1;
          // Snapshots are not yet registered; byte 0 is the constant header.
          tx_data_next = HEADER;
        end
        if (!wr_uart) begin
          cyc_next = sat_inc(cyc);
        end
      end
      SEND: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (tx_done_tick) begin
          if (idx < LAST_IDX) begin
            idx_next     = idx + 3'd1;
            state_next   = SEND;
            tx_data_next = frame_byte(idx + 3'd1, snap_cyc, snap_pc, snap_acc);
          end else begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (!wr_uart) begin
          state_next = IDLE;
          cyc_next   = 16'h0000;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    tx_start_next = (state_next == SEND);
    busy_next     = (state_next == SEND) || (state_next == WAIT);
    done_next     = (state_next == DONE);
  end

  // ---- registered control and outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 3'd0;
      wr_uart_p1 <= 1'b0;
      cyc        <= 16'h0000;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      wr_uart_p1 <= wr_uart;
      cyc        <= cyc_next;
      tx_start   <= tx_start_next;
      tx_data    <= tx_data_next;
      busy       <= busy_next;
      done       <= done_next;
    end
  end

  // ---- snapshot registers (data only, loaded on trigger) ----
  always_ff @(posedge clk) begin
    if (load_snap) begin
      snap_cyc <= cyc;
      snap_pc  <= 16'(pc);
      snap_acc <= acc;
    end
  end

`ifndef SYNTHESIS
  idx_in_range: assert property (@(posedge clk) disable iff (reset)
    idx <= LAST_IDX);
  start_one_shot: assert property (@(posedge clk) disable iff (reset)
    tx_start |=> !tx_start);
  busy_done_excl: assert property (@(posedge clk)
    !(busy && done));
`endif

endmodule

// File: tb/tb_bip_debug_tx.sv
// Testbench for bip_debug_tx: a UART TX responder answers each tx_start
// LAT cycles later; a monitor collects every byte offered on tx_start.
// Test tasks push expected frames to a queue and compare against the
// collected bytes once the frame completes.
module tb_bip_debug_tx;

  localparam int PCW = 11;
  localparam int LAT = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           wr_uart;
  logic [PCW-1:0] pc;
  logic [15:0]    acc;
  logic           tx_done_tick;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_t[$];
  int         cyc_n = 0;
  int         cd = 0;
  bit         rnd_io = 1'b0;

  always #5 clk = ~clk;

  bip_debug_tx #(.PC_WIDTH(PCW), .HEADER(8'hA5)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_uart      (wr_uart),
    .pc           (pc),
    .acc          (acc),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .busy         (busy),
    .done         (done)
  );

  // UART TX model and byte monitor.
  initial begin
    tx_done_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc_n++;
      tx_done_tick = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) tx_done_tick = 1'b1;
      end
      if (tx_start === 1'b1) begin
        obs_q.push_back(tx_data);
        obs_t.push_back(cyc_n);
        cd = LAT;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [15:0] c, input logic [PCW-1:0] p,
                            input logic [15:0] a);
    logic [15:0] px;
    px = 16'(p);
    exp_q.push_back(8'hA5);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
    exp_q.push_back(px[15:8]);
    exp_q.push_back(px[7:0]);
    exp_q.push_back(a[15:8]);
    exp_q.push_back(a[7:0]);
  endtask

  // Reset, idle for idle_n clocks with wr_uart low, then raise wr_uart.
  // On return the trigger cycle is being driven.
  task automatic start_frame(input int idle_n, input logic [PCW-1:0] p,
                             input logic [15:0] a);
    logic [15:0] c;
    reset   = 1'b1;
    wr_uart = 1'b0;
    cd      = 0;
    step();
    reset = 1'b0;
    obs_q.delete();
    obs_t.delete();
    exp_q.delete();
    for (int i = 0; i < idle_n; i++) step();
    c = (idle_n > 65535) ? 16'hFFFF : 16'(idle_n);
    pc      = p;
    acc     = a;
    wr_uart = 1'b1;
    push_frame(c, p, a);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (rnd_io) begin
        pc  = PCW'($urandom);
        acc = 16'($urandom);
      end
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_uart = 1'b0; pc = '0; acc = '0;
    step();
    step();
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  task automatic test_basic();
    bit ok;
    logic [7:0] e, o;
    int gaps_bad;
    start_frame(20, 11'h005, 16'h1234);
    step();
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL basic_first_start got %b want 1", tx_start); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL basic_first_data got %h want a5", tx_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise got %b want 1", busy); end
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout done got %b want 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall got %b want 0", busy); end
    checks++; if (obs_q.size() != 7) begin errors++; $display("FAIL basic_count got %0d want 7", obs_q.size()); end
    gaps_bad = 0;
    for (int i = 1; i < obs_t.size(); i++)
      if (obs_t[i] - obs_t[i-1] != LAT + 1) gaps_bad++;
    checks++; if (gaps_bad != 0) begin errors++; $display("FAIL basic_spacing got %0d bad gaps want 0", gaps_bad); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = 8'hxx;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL basic_byte got %h want %h", o, e); end
    end
    obs_t.delete();
  endtask

  // Continues from test_basic with wr_uart still high.
  task automatic test_hold_done();
    bit ok;
    logic [7:0] e, o;
    int dcount;
    obs_q.delete();
    obs_t.delete();
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done === 1'b1) dcount++;
    end
    checks++; if (dcount != 10) begin errors++; $display("FAIL hold_done_level got %0d want 10", dcount); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL hold_retrigger got %0d starts want 0", obs_q.size()); end
    wr_uart = 1'b0;
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL hold_done_clear got %b want 0", done); end
    step();
    pc = 11'h3AB; acc = 16'hBEEF; wr_uart = 1'b1;
    push_frame(16'h0001, 11'h3AB, 16'hBEEF);
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_timeout done got %b want 1", done); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = 8'hxx;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL hold_byte got %h want %h", o, e); end
    end
  endtask

  task automatic test_snapshot();
    bit ok;
    logic [7:0] e, o;
    start_frame(5, 11'h1A2, 16'hC3D4);
    rnd_io = 1'b1;
    wait_done(200, ok);
    rnd_io = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL snap_timeout done got %b want 1", done); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = 8'hxx;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL snap_byte got %h want %h", o, e); end
    end
  endtask

  task automatic test_pc_width();
    bit ok;
    logic [7:0] e, o;
    start_frame(2, 11'h7FF, 16'h00FF);
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pcw_timeout done got %b want 1", done); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = 8'hxx;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL pcw_byte got %h want %h", o, e); end
    end
  endtask

  task automatic test_saturation();
    bit ok;
    logic [7:0] e, o;
    start_frame(70000, 11'h000, 16'hFFFF);
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_timeout done got %b want 1", done); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = 8'hxx;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL sat_byte got %h want %h", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] e, o;
    int n;
    start_frame(3, 11'h055, 16'h5555);
    n = 0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      step();
      if (tx_start === 1'b1) n++;
    end
    checks++; if (n != 4) begin errors++; $display("FAIL mid_reach_byte3 got %0d starts want 4", n); end
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_in_wait got %b want 1", busy); end
    reset = 1'b1; wr_uart = 1'b0; cd = 0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after_reset got %b want 0", busy); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL mid_start_after_reset got %b want 0", tx_start); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done_after_reset got %b want 0", done); end
    reset = 1'b0;
    obs_q.delete();
    obs_t.delete();
    exp_q.delete();
    step();
    pc = 11'h123; acc = 16'h4567; wr_uart = 1'b1;
    push_frame(16'h0001, 11'h123, 16'h4567);
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_timeout done got %b want 1", done); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = 8'hxx;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL mid_byte got %h want %h", o, e); end
    end
  endtask

  initial begin
    reset = 1'b1;
    wr_uart = 1'b0;
    pc = '0;
    acc = '0;
    test_reset();
    test_basic();
    test_hold_done();
    test_snapshot();
    test_pc_width();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
